nn_sequencer: RTL and testbench

Parametrised control sequencer for the neural-network datapath, driving coefficient load, feedforward, mini-batch training and coefficient write-back. Compared with the previous control unit it adds:
- a start/done handshake;
- runtime mode, batch and iteration limits;
- batch-wise address advance with epoch wrap;
- a graceful stop;
- an explicit end-of-data flag in place of an in-band sentinel value.

It sits between the coefficient/data BRAMs and the layer/backprop register arrays.

---
 rtl/nn_sequencer_pkg.sv | 52 +++++
 rtl/nn_sequencer_coef_walker.sv | 104 ++++++++++
 rtl/nn_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_nn_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_sequencer_pkg.sv
// Shared definitions for the NN control sequencer: state encodings,
// default layer geometry and helpers that unpack the packed layer-size vector.
// Purely declarative; no timing or flow control.
package nn_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FF    = 3'd2,
        ST_TRAIN = 3'd3,
        ST_SAVE  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Upper bound on layer count handled by the unpack helpers; LR vectors
    // are zero-extended to this width before indexing.
    localparam int LR_MAXL = 16;
    localparam int LR_MAXW = 32 * LR_MAXL;

    // Default network: 2 inputs -> 2 hidden -> 1 output.
    localparam int                      LTOT_DEF = 3;
    localparam logic [32*LTOT_DEF-1:0]  LR_DEF   = {32'd1, 32'd2, 32'd2};
    localparam int                      ND_DEF   = 3;
    localparam int                      WT_DEF   = 6;

    // Size of layer i; out-of-range indices read as 0 so callers can probe
    // one past the last layer without special-casing.
    function automatic logic [31:0] lr_at(input logic [LR_MAXW-1:0] lr, input int i);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < LR_MAXL; j++) begin
            if (j == i) begin
                r = lr[j*32 +: 32];
            end
        end
        return r;
    endfunction

    // Coefficient count implied by the layer sizes: each node of layer l
    // owns one weight per node of layer l-1 plus a bias.
    function automatic int nc_calc(input logic [LR_MAXW-1:0] lr, input int ltot);
        int s;
        s = 0;
        for (int l = 1; l < LR_MAXL; l++) begin
            if (l < ltot) begin
                s += int'(lr_at(lr, l)) * (int'(lr_at(lr, l - 1)) + 1);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/nn_sequencer_coef_walker.sv
// Layer/node/coefficient cursor producing one-hot node strobes (load) or a
// one-hot coefficient select (save). Outputs registered: one cycle after en_i.
// No backpressure; the cursor advances every cycle en_i is high.
//   en_i/first_i : drive a valid position next cycle; first_i restarts at coefficient 0
//   sel_i        : 0 routes to we_o/coef_sel_o, 1 routes to bp_we_o
//   we_o (ND), coef_sel_o (A), bp_we_o (NC) : MSB = first node/coefficient
module nn_sequencer_coef_walker
    import nn_sequencer_pkg::*;
#(
    parameter int                   LTOT = LTOT_DEF,
    parameter logic [32*LTOT-1:0]   LR   = LR_DEF,
    parameter int                   ND   = ND_DEF,
    parameter int                   NC   = WT_DEF + ND_DEF,
    parameter int                   A    = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic            first_i,
    input  logic            sel_i,
    output logic [ND-1:0]   we_o,
    output logic [A-1:0]    coef_sel_o,
    output logic [NC-1:0]   bp_we_o
);

    localparam int                  LYW    = $clog2(LTOT + 1);
    localparam int                  GW     = $clog2(ND + 1);
    localparam logic [LR_MAXW-1:0]  LRX    = LR_MAXW'(LR);
    localparam int                  NC_SUM = nc_calc(LRX, LTOT);

    logic [LYW-1:0] lay_q, lay_d;       // current layer, 1..LTOT-1
    logic [A-1:0]   node_q, node_d;     // node within the layer
    logic [A-1:0]   cf_q, cf_d;         // coefficient within the node
    logic [GW-1:0]  gnode_q, gnode_d;   // node index across all layers
    logic [NC-1:0]  bp_oh_q, bp_oh_d;   // one-hot coefficient cursor
    logic [A-1:0]   ld_m1;
    logic [A-1:0]   ldp;
    logic [ND-1:0]  node_oh;

    // ldp is both the previous-layer size and the bias index within a node.
    assign ld_m1 = A'(lr_at(LRX, int'(lay_q)) - 32'd1);
    assign ldp   = A'(lr_at(LRX, int'(lay_q) - 1));

    always_comb begin
        lay_d   = lay_q;
        node_d  = node_q;
        cf_d    = cf_q;
        gnode_d = gnode_q;
        bp_oh_d = bp_oh_q;
        node_oh = '0;
        if (en_i && first_i) begin
            lay_d   = LYW'(1);
            node_d  = '0;
            cf_d    = '0;
            gnode_d = '0;
            bp_oh_d = NC'(1) << (NC - 1);
        end else if (en_i) begin
            bp_oh_d = bp_oh_q >> 1;
            if (cf_q == ldp) begin
                cf_d    = '0;
                gnode_d = gnode_q + GW'(1);
                if (node_q == ld_m1) begin
                    node_d = '0;
                    lay_d  = lay_q + LYW'(1);
                end else begin
                    node_d = node_q + A'(1);
                end
            end else begin
                cf_d = cf_q + A'(1);
            end
        end
        for (int i = 0; i < ND; i++) begin
            node_oh[i] = (gnode_d == GW'(ND - 1 - i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lay_q      <= LYW'(1);
            node_q     <= '0;
            cf_q       <= '0;
            gnode_q    <= '0;
            bp_oh_q    <= '0;
            we_o       <= '0;
            coef_sel_o <= '0;
            bp_we_o    <= '0;
        end else begin
            lay_q      <= lay_d;
            node_q     <= node_d;
            cf_q       <= cf_d;
            gnode_q    <= gnode_d;
            bp_oh_q    <= bp_oh_d;
            we_o       <= (en_i && !sel_i) ? node_oh : '0;
            coef_sel_o <= (en_i && !sel_i) ? cf_d : '0;
            bp_we_o    <= (en_i && sel_i) ? bp_oh_d : '0;
        end
    end

    // Layer geometry must account for every coefficient the sequencer walks.
    always_ff @(posedge clk) begin
        assert (NC_SUM == NC);
    end

endmodule

// File: rtl/nn_sequencer.sv
// Control sequencer for coefficient load, feedforward, mini-batch training and write-back.
// All outputs registered; start to first LOAD address is one cycle.
// No backpressure: start is ignored unless IDLE/DONE; stop is a graceful, sticky request.
//   in : clk, rst (async active-low), start, mode, batch, data_len, max_it, stop, x_last
//   out: x/y/t/nd_addr, e_nd, we, coef_sel, acc_en, bp_we, dtb, nd_we, y_we, state, busy, done, iter
module nn_sequencer
    import nn_sequencer_pkg::*;
#(
    parameter int                   LTOT = LTOT_DEF,
    parameter logic [32*LTOT-1:0]   LR   = LR_DEF,
    parameter int                   ND   = ND_DEF,
    parameter int                   WT   = WT_DEF,
    parameter int                   NC   = WT + ND,
    parameter int                   A    = 10,
    parameter int                   T0   = 10,
    parameter int                   IW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic [A-1:0]    batch,
    input  logic [A-1:0]    data_len,
    input  logic [IW-1:0]   max_it,
    input  logic            stop,
    input  logic            x_last,
    output logic [A-1:0]    x_addr,
    output logic [A-1:0]    y_addr,
    output logic [A-1:0]    t_addr,
    output logic [A-1:0]    nd_addr,
    output logic            e_nd,
    output logic [ND-1:0]   we,
    output logic [A-1:0]    coef_sel,
    output logic            acc_en,
    output logic [NC-1:0]   bp_we,
    output logic            dtb,
    output logic            nd_we,
    output logic            y_we,
    output logic [2:0]      state,
    output logic            busy,
    output logic            done,
    output logic [IW-1:0]   iter
);

    localparam int KW = $clog2(NC + 2);

    state_e         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;           // step within LOAD/SAVE, 0..NC
    logic           mode_q, mode_d;
    logic [A-1:0]   batch_q, batch_d;
    logic [A-1:0]   len_q, len_d;
    logic [IW-1:0]  maxit_q, maxit_d;
    logic [IW-1:0]  iter_q, iter_d;
    logic [A-1:0]   base_q, base_d;     // first sample of the current batch
    logic [A-1:0]   cnt_q, cnt_d;       // sample within the batch
    logic           stop_q, stop_d;
    logic           stop_seen;
    logic [A-1:0]   x_q, x_d, y_q, y_d, t_q, t_d, nd_q, nd_d;
    logic           e_nd_q, e_nd_d, acc_en_q, acc_en_d, dtb_q, dtb_d;
    logic           nd_we_q, nd_we_d, y_we_q, y_we_d, busy_q, busy_d, done_q, done_d;
    logic [A+1:0]   span;               // base + 2*batch, widened to avoid overflow
    logic [A-1:0]   nb;
    logic           wk_en, wk_first, wk_sel;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        mode_d    = mode_q;
        batch_d   = batch_q;
        len_d     = len_q;
        maxit_d   = maxit_q;
        iter_d    = iter_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        t_d       = t_q;
        stop_seen = stop_q | stop;
        stop_d    = (state_q != ST_IDLE) ? stop_seen : stop_q;
        span      = {2'b00, base_q} + {1'b0, batch_q, 1'b0};
        nb        = base_q + batch_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    k_d     = '0;
                    mode_d  = mode;
                    batch_d = batch;
                    len_d   = data_len;
                    maxit_d = max_it;
                    iter_d  = '0;
                    base_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                    t_d     = A'(T0);
                    stop_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                // Feedforward has no iteration to finish, so stop ends the load at once.
                if (!mode_q && stop_seen) begin
                    state_d = ST_DONE;
                end else if (k_q == KW'(NC)) begin
                    state_d = mode_q ? ST_TRAIN : ST_FF;
                    cnt_d   = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_FF: begin
                if (x_last || stop_seen) begin
                    state_d = ST_DONE;
                end else begin
                    x_d = x_q + A'(1);
                    y_d = y_q + A'(1);
                end
            end
            ST_TRAIN: begin
                if (cnt_q == batch_q - A'(1)) begin
                    state_d = ST_SAVE;
                    k_d     = '0;
                    iter_d  = iter_q + IW'(1);
                    // Wrap when the following batch would run past the dataset.
                    if (span > {2'b00, len_q}) begin
                        base_d = '0;
                    end else begin
                        base_d = nb;
                    end
                    x_d = base_d;
                    y_d = base_d;
                    t_d = A'(T0) + base_d;
                end else begin
                    cnt_d = cnt_q + A'(1);
                    x_d   = x_q + A'(1);
                    y_d   = y_q + A'(1);
                    t_d   = t_q + A'(1);
                end
            end
            ST_SAVE: begin
                if (k_q == KW'(NC)) begin
                    if (iter_q == maxit_q || stop_seen) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                        k_d     = '0;
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Output registers are loaded from the next state so they line up
        // with the cycle they describe.
        e_nd_d   = (state_d == ST_LOAD);
        acc_en_d = (state_d == ST_TRAIN);
        dtb_d    = (state_d == ST_SAVE);
        nd_we_d  = (state_d == ST_SAVE) && (k_d != '0);
        y_we_d   = (state_d == ST_FF);
        busy_d   = (state_d == ST_LOAD) || (state_d == ST_FF) ||
                   (state_d == ST_TRAIN) || (state_d == ST_SAVE);
        done_d   = (state_d == ST_DONE);

        nd_d = nd_q;
        if (state_d == ST_LOAD) begin
            if (k_d < KW'(NC)) begin
                nd_d = A'(k_d);
            end
        end else if (state_d == ST_SAVE) begin
            // Write-back trails the walk by one cycle to match the read latency.
            nd_d = (k_d == '0) ? '0 : A'(k_d - KW'(1));
        end

        wk_en    = ((state_d == ST_LOAD) || (state_d == ST_SAVE)) && (k_d != '0);
        wk_first = (k_d == KW'(1));
        wk_sel   = (state_d == ST_SAVE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            mode_q   <= 1'b0;
            batch_q  <= '0;
            len_q    <= '0;
            maxit_q  <= '0;
            iter_q   <= '0;
            base_q   <= '0;
            cnt_q    <= '0;
            stop_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            t_q      <= A'(T0);
            nd_q     <= '0;
            e_nd_q   <= 1'b0;
            acc_en_q <= 1'b0;
            dtb_q    <= 1'b0;
            nd_we_q  <= 1'b0;
            y_we_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            mode_q   <= mode_d;
            batch_q  <= batch_d;
            len_q    <= len_d;
            maxit_q  <= maxit_d;
            iter_q   <= iter_d;
            base_q   <= base_d;
            cnt_q    <= cnt_d;
            stop_q   <= stop_d;
            x_q      <= x_d;
            y_q      <= y_d;
            t_q      <= t_d;
            nd_q     <= nd_d;
            e_nd_q   <= e_nd_d;
            acc_en_q <= acc_en_d;
            dtb_q    <= dtb_d;
            nd_we_q  <= nd_we_d;
            y_we_q   <= y_we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    nn_sequencer_coef_walker #(
        .LTOT (LTOT),
        .LR   (LR),
        .ND   (ND),
        .NC   (NC),
        .A    (A)
    ) u_walker (
        .clk        (clk),
        .rst_n      (rst),
        .en_i       (wk_en),
        .first_i    (wk_first),
        .sel_i      (wk_sel),
        .we_o       (we),
        .coef_sel_o (coef_sel),
        .bp_we_o    (bp_we)
    );

    // Coefficients are weights followed by one bias per node.
    always_ff @(posedge clk) begin
        assert (NC == WT + ND);
    end

    assign x_addr  = x_q;
    assign y_addr  = y_q;
    assign t_addr  = t_q;
    assign nd_addr = nd_q;
    assign e_nd    = e_nd_q;
    assign acc_en  = acc_en_q;
    assign dtb     = dtb_q;
    assign nd_we   = nd_we_q;
    assign y_we    = y_we_q;
    assign state   = state_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign iter    = iter_q;

endmodule

// File: tb/tb_nn_sequencer.sv
module tb_nn_sequencer;

    localparam int A  = 10;
    localparam int IW = 16;
    localparam int ND = 3;
    localparam int NC = 9;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           mode = 1'b0;
    logic           stop = 1'b0;
    logic           x_last = 1'b0;
    logic [A-1:0]   batch = '0;
    logic [A-1:0]   data_len = '0;
    logic [IW-1:0]  max_it = '0;

    logic [A-1:0]   x_addr, y_addr, t_addr, nd_addr, coef_sel;
    logic           e_nd, acc_en, dtb, nd_we, y_we, busy, done;
    logic [ND-1:0]  we;
    logic [NC-1:0]  bp_we;
    logic [2:0]     state;
    logic [IW-1:0]  iter;

    int             checks = 0;
    int             errors = 0;
    logic [31:0]    sig_a, sig_b;

    nn_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .batch    (batch),
        .data_len (data_len),
        .max_it   (max_it),
        .stop     (stop),
        .x_last   (x_last),
        .x_addr   (x_addr),
        .y_addr   (y_addr),
        .t_addr   (t_addr),
        .nd_addr  (nd_addr),
        .e_nd     (e_nd),
        .we       (we),
        .coef_sel (coef_sel),
        .acc_en   (acc_en),
        .bp_we    (bp_we),
        .dtb      (dtb),
        .nd_we    (nd_we),
        .y_we     (y_we),
        .state    (state),
        .busy     (busy),
        .done     (done),
        .iter     (iter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // batch=2, data_len=5, max_it=3: batch bases 0, 2, 0; optional stray start in iteration 2.
    task automatic train_run(input bit pulse, output logic [31:0] sig);
        int base;
        sig = 32'h0;
        start = 1'b1; mode = 1'b1; batch = 10'd2; data_len = 10'd5; max_it = 16'd3;
        step();
        start = 1'b0;
        for (int it = 0; it < 3; it++) begin
            base = (it == 1) ? 2 : 0;
            for (int k = 0; k <= NC; k++) begin
                chk("tr_ld_state", 32'(state), 1);
                if (k == 0) chk("tr_ld_nd_addr0", 32'(nd_addr), 0);
                sig = (sig * 32'd31) ^ 32'({state, x_addr, bp_we, we, acc_en, nd_we});
                step();
            end
            for (int c = 0; c < 2; c++) begin
                chk("tr_state", 32'(state), 3);
                chk("tr_acc_en", 32'(acc_en), 1);
                chk("tr_x_addr", 32'(x_addr), base + c);
                chk("tr_t_addr", 32'(t_addr), 10 + base + c);
                chk("tr_iter", 32'(iter), it);
                if (pulse && it == 1 && c == 0) start = 1'b1;
                sig = (sig * 32'd31) ^ 32'({state, x_addr, bp_we, we, acc_en, nd_we});
                step();
                start = 1'b0;
            end
            for (int k = 0; k <= NC; k++) begin
                chk("sv_state", 32'(state), 4);
                chk("sv_dtb", 32'(dtb), 1);
                chk("sv_nd_we", 32'(nd_we), (k == 0) ? 0 : 1);
                chk("sv_bp_we", 32'(bp_we), (k == 0) ? 0 : (1 << (NC - k)));
                if (k >= 1) chk("sv_nd_addr", 32'(nd_addr), k - 1);
                sig = (sig * 32'd31) ^ 32'({state, x_addr, bp_we, we, acc_en, nd_we});
                step();
            end
            chk("tr_iter_after_save", 32'(iter), it + 1);
        end
        chk("tr_done_state", 32'(state), 5);
        chk("tr_done_flag", 32'({busy, done}), 1);
        chk("tr_x_next_base", 32'(x_addr), 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) step();
        chk("rst_state", 32'(state), 0);
        chk("rst_t_addr", 32'(t_addr), 10);
        chk("rst_xy_addr", 32'({x_addr, y_addr}), 0);
        chk("rst_nd_addr", 32'(nd_addr), 0);
        chk("rst_busy_done", 32'({busy, done}), 0);
        chk("rst_strobes", 32'({we, bp_we, e_nd, acc_en, dtb, nd_we, y_we}), 0);
        chk("rst_iter", 32'(iter), 0);
        rst = 1'b1;
        step();
        chk("idle_hold", 32'(state), 0);

        // Feedforward: LOAD walk then FF until x_last at x_addr=5
        start = 1'b1; mode = 1'b0; batch = 10'd1; data_len = 10'd10; max_it = 16'd1;
        step();
        start = 1'b0;
        for (int k = 0; k <= NC; k++) begin
            chk("ld_state", 32'(state), 1);
            chk("ld_e_nd", 32'(e_nd), 1);
            chk("ld_busy", 32'(busy), 1);
            if (k < NC) chk("ld_nd_addr", 32'(nd_addr), k);
            chk("ld_we", 32'(we), (k == 0) ? 0 : (4 >> ((k - 1) / 3)));
            chk("ld_coef_sel", 32'(coef_sel), (k == 0) ? 0 : ((k - 1) % 3));
            step();
        end
        for (int i = 0; i <= 5; i++) begin
            chk("ff_state", 32'(state), 2);
            chk("ff_y_we", 32'(y_we), 1);
            chk("ff_x_addr", 32'(x_addr), i);
            chk("ff_y_addr", 32'(y_addr), i);
            x_last = (i == 5);
            step();
        end
        x_last = 1'b0;
        chk("ff_done_state", 32'(state), 5);
        chk("ff_done_flags", 32'({busy, done}), 1);
        chk("ff_x_hold", 32'(x_addr), 5);
        chk("ff_y_we_off", 32'(y_we), 0);
        step();
        chk("ff_done_stays", 32'(state), 5);
        chk("ff_x_hold2", 32'(x_addr), 5);

        // stop and x_last on the same FF cycle
        start = 1'b1; mode = 1'b0;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("ffs_state", 32'(state), 2);
        chk("ffs_x_cleared", 32'(x_addr), 0);
        stop = 1'b1; x_last = 1'b1;
        step();
        stop = 1'b0; x_last = 1'b0;
        chk("ffs_done", 32'(state), 5);
        chk("ffs_x_hold", 32'(x_addr), 0);
        step();
        chk("ffs_done_stays", 32'(state), 5);

        // stop during a feedforward LOAD
        start = 1'b1; mode = 1'b0;
        step();
        start = 1'b0;
        repeat (2) step();
        chk("lds_state", 32'(state), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("lds_done", 32'(state), 5);
        chk("lds_strobes_off", 32'({we, e_nd}), 0);

        // Training with wrap, then the same run with a stray start in TRAIN
        train_run(1'b0, sig_a);
        train_run(1'b1, sig_b);
        chk("start_ignored_trace", sig_b, sig_a);

        // stop during the first TRAIN with max_it=10
        start = 1'b1; mode = 1'b1; batch = 10'd2; data_len = 10'd5; max_it = 16'd10;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("st_train", 32'(state), 3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("st_train2", 32'(state), 3);
        step();
        for (int k = 0; k <= NC; k++) begin
            chk("st_save", 32'(state), 4);
            step();
        end
        chk("st_done", 32'(state), 5);
        chk("st_iter", 32'(iter), 1);
        chk("st_done_flag", 32'(done), 1);

        // Asynchronous reset mid-SAVE at k=4
        start = 1'b1; mode = 1'b1; batch = 10'd1; data_len = 10'd5; max_it = 16'd5;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("rs_train", 32'(state), 3);
        step();
        repeat (4) step();
        chk("rs_save_state", 32'(state), 4);
        chk("rs_save_bp_we", 32'(bp_we), 1 << (NC - 4));
        #2 rst = 1'b0;
        #1;
        chk("rs_async_state", 32'(state), 0);
        chk("rs_async_bp_nd_we", 32'({bp_we, nd_we}), 0);
        step();
        chk("rs_state", 32'(state), 0);
        chk("rs_bp_we", 32'(bp_we), 0);
        chk("rs_nd_we", 32'(nd_we), 0);
        chk("rs_t_addr", 32'(t_addr), 10);
        chk("rs_iter", 32'(iter), 0);
        rst = 1'b1;
        step();
        chk("rs_idle", 32'(state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
